id_ex_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the main decoder and ALU decoder.
//  It captures decoded control (regwrite..jump, alucontrol) and datapath fields at the end of ID and presents them to EX.
//  It also contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble.
//  It handles the external pipeline stall and the branch/jump flush.

---
 rtl/id_ex_reg_pkg.sv | 15 +
 rtl/id_ex_reg_if.sv | 34 +++
 rtl/id_ex_reg_load_use_detect.sv | 13 +
 rtl/id_ex_reg.sv | 74 +++++++
 tb/tb_id_ex_reg.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: shared widths and control-vector types for the ID/EX stage
package id_ex_reg_pkg;
  localparam int REG_W = 5;
  localparam int ALUCTRL_W = 3;
  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic branch;
    logic memwrite;
    logic memtoreg;
    logic jump;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: decode-side fields in, execute-side fields and hazard stalls out
interface id_ex_reg_if
  import id_ex_reg_pkg::*;
#(
  parameter int DW = 32,
  parameter int ALUCW = ALUCTRL_W,
  parameter int CNTW = 32
);
  logic stall_i, flush_i;
  logic regwrite_d, regdst_d, alusrc_d, branch_d, memWrite_d, memToReg_d, jump_d;
  logic [ALUCW-1:0] alucontrol_d;
  logic [REG_W-1:0] rs_d, rt_d, rd_d;
  logic [DW-1:0] srca_d, srcb_d, signimm_d, pcplus4_d;
  logic regwrite_e, regdst_e, alusrc_e, branch_e, memWrite_e, memToReg_e, jump_e;
  logic [ALUCW-1:0] alucontrol_e;
  logic [REG_W-1:0] rs_e, rt_e, rd_e;
  logic [DW-1:0] srca_e, srcb_e, signimm_e, pcplus4_e;
  logic valid_e, stall_f_o, stall_d_o;
  logic [CNTW-1:0] lu_bubbles_o;
  modport master (
    output stall_i, flush_i, regwrite_d, regdst_d, alusrc_d, branch_d, memWrite_d, memToReg_d,
           jump_d, alucontrol_d, rs_d, rt_d, rd_d, srca_d, srcb_d, signimm_d, pcplus4_d,
    input  regwrite_e, regdst_e, alusrc_e, branch_e, memWrite_e, memToReg_e, jump_e,
           alucontrol_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e, pcplus4_e,
           valid_e, stall_f_o, stall_d_o, lu_bubbles_o
  );
  modport slave (
    input  stall_i, flush_i, regwrite_d, regdst_d, alusrc_d, branch_d, memWrite_d, memToReg_d,
           jump_d, alucontrol_d, rs_d, rt_d, rd_d, srca_d, srcb_d, signimm_d, pcplus4_d,
    output regwrite_e, regdst_e, alusrc_e, branch_e, memWrite_e, memToReg_e, jump_e,
           alucontrol_e, rs_e, rt_e, rd_e, srca_e, srcb_e, signimm_e, pcplus4_e,
           valid_e, stall_f_o, stall_d_o, lu_bubbles_o
  );
endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX is still fetching
module load_use_detect
  import id_ex_reg_pkg::*;
(
  input  logic             valid_e,
  input  logic             memToReg_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  output logic             lu_haz
);
  assign lu_haz = valid_e & memToReg_e & (rt_e != '0) & ((rt_e == rs_d) | (rt_e == rt_d));
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use bubble insertion, stall hold and flush
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DW = 32,
  parameter int ALUCW = ALUCTRL_W,
  parameter int CNTW = 32
) (
  input logic       clk,
  input logic       rst,
  id_ex_reg_if.slave bus
);
  ctrl_t ctrl_d, ctrl_q;
  logic [ALUCW-1:0] aluc_q;
  logic [REG_W-1:0] rs_q, rt_q, rd_q;
  logic [DW-1:0] srca_q, srcb_q, imm_q, pc4_q;
  logic valid_q, lu_haz, bubble;
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign ctrl_d = {bus.regwrite_d, bus.regdst_d, bus.alusrc_d, bus.branch_d,
                   bus.memWrite_d, bus.memToReg_d, bus.jump_d};
  load_use_detect u_lud (
    .valid_e   (valid_q),
    .memToReg_e(ctrl_q.memtoreg),
    .rt_e      (rt_q),
    .rs_d      (bus.rs_d),
    .rt_d      (bus.rt_d),
    .lu_haz    (lu_haz)
  );
  assign bubble = bus.flush_i | lu_haz;
  assign bus.stall_f_o = lu_haz | bus.stall_i;
  assign bus.stall_d_o = lu_haz | bus.stall_i;
  // count only bubbles actually inserted by a load-use hazard, saturating at all-ones
  always_comb cnt_d = (lu_haz && !bus.stall_i && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
  // stage register: reset clears, external stall holds, flush/hazard loads an inert bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= BUBBLE;
      aluc_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall_i) begin
      ctrl_q  <= bubble ? BUBBLE : ctrl_d;
      aluc_q  <= bubble ? '0 : bus.alucontrol_d;
      rs_q    <= bubble ? '0 : bus.rs_d;
      rt_q    <= bubble ? '0 : bus.rt_d;
      rd_q    <= bubble ? '0 : bus.rd_d;
      srca_q  <= bubble ? '0 : bus.srca_d;
      srcb_q  <= bubble ? '0 : bus.srcb_d;
      imm_q   <= bubble ? '0 : bus.signimm_d;
      pc4_q   <= bubble ? '0 : bus.pcplus4_d;
      valid_q <= !bubble;
    end
  end
  // bubble counter, cleared only by reset
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign {bus.regwrite_e, bus.regdst_e, bus.alusrc_e, bus.branch_e,
          bus.memWrite_e, bus.memToReg_e, bus.jump_e} = ctrl_q;
  assign bus.alucontrol_e = aluc_q;
  assign bus.rs_e         = rs_q;
  assign bus.rt_e         = rt_q;
  assign bus.rd_e         = rd_q;
  assign bus.srca_e       = srca_q;
  assign bus.srcb_e       = srcb_q;
  assign bus.signimm_e    = imm_q;
  assign bus.pcplus4_e    = pc4_q;
  assign bus.valid_e      = valid_q;
  assign bus.lu_bubbles_o = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for the ID/EX register, hazard stall and bubble counter
module tb_id_ex_reg;
  localparam int S_VALID = 0, S_CTRL = 1, S_ALUC = 2, S_RS = 3, S_RT = 4, S_RD = 5, S_SRCA = 6,
                 S_SRCB = 7, S_IMM = 8, S_PC4 = 9, S_STALLF = 10, S_STALLD = 11, S_CNT = 12;
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;
  logic clk = 0, rst;
  int cyc = 0, total = 0, passed = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] got;
  id_ex_reg_if #(.CNTW(2)) b ();
  id_ex_reg #(.CNTW(2)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] obs(int s);
    case (s)
      S_VALID:  return {31'b0, b.valid_e};
      S_CTRL:   return {25'b0, b.regwrite_e, b.regdst_e, b.alusrc_e, b.branch_e,
                        b.memWrite_e, b.memToReg_e, b.jump_e};
      S_ALUC:   return {29'b0, b.alucontrol_e};
      S_RS:     return {27'b0, b.rs_e};
      S_RT:     return {27'b0, b.rt_e};
      S_RD:     return {27'b0, b.rd_e};
      S_SRCA:   return b.srca_e;
      S_SRCB:   return b.srcb_e;
      S_IMM:    return b.signimm_e;
      S_PC4:    return b.pcplus4_e;
      S_STALLF: return {31'b0, b.stall_f_o};
      S_STALLD: return {31'b0, b.stall_d_o};
      S_CNT:    return {30'b0, b.lu_bubbles_o};
      default:  return '0;
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      got = obs(e.sel);
      total++;
      if (e.cyc != cyc || got !== e.val)
        $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", e.name, e.cyc, got, e.val);
      else passed++;
    end
  end
  task automatic chk(int dc, int sel, logic [31:0] v, string n);
    q.push_back('{cyc + dc, sel, v, n});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(logic [6:0] c, logic [2:0] a, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                     logic [31:0] sa, logic [31:0] sb, logic [31:0] im, logic [31:0] pc);
    {b.regwrite_d, b.regdst_d, b.alusrc_d, b.branch_d, b.memWrite_d, b.memToReg_d, b.jump_d} = c;
    b.alucontrol_d = a;
    b.rs_d = rs;
    b.rt_d = rt;
    b.rd_d = rd;
    b.srca_d = sa;
    b.srcb_d = sb;
    b.signimm_d = im;
    b.pcplus4_d = pc;
  endtask
  initial begin
    rst = 1;
    b.stall_i = 0;
    b.flush_i = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk(0, S_VALID, 0, "rst_valid");
    chk(0, S_CTRL, 0, "rst_ctrl");
    chk(0, S_CNT, 0, "rst_cnt");
    rst = 0;
    drv(7'h60, 3'b010, 8, 9, 10, 32'h5, 32'h7, 32'h10, 32'h104);
    chk(0, S_STALLF, 0, "norm_nostall");
    chk(1, S_VALID, 1, "norm_valid");
    chk(1, S_CTRL, 32'h60, "norm_ctrl");
    chk(1, S_ALUC, 2, "norm_aluc");
    chk(1, S_RS, 8, "norm_rs");
    chk(1, S_RT, 9, "norm_rt");
    chk(1, S_RD, 10, "norm_rd");
    chk(1, S_SRCA, 32'h5, "norm_srca");
    chk(1, S_SRCB, 32'h7, "norm_srcb");
    chk(1, S_IMM, 32'h10, "norm_imm");
    chk(1, S_PC4, 32'h104, "norm_pc4");
    tick();
    rst = 1;
    b.stall_i = 1;
    drv(7'h7f, 3'h7, 1, 2, 3, 32'hdead, 32'hbeef, 1, 2);
    chk(0, S_STALLF, 1, "ext_stall_f");
    chk(1, S_VALID, 0, "rststall_valid");
    chk(1, S_CTRL, 0, "rststall_ctrl");
    chk(1, S_SRCA, 0, "rststall_srca");
    chk(1, S_CNT, 0, "rststall_cnt");
    tick();
    rst = 0;
    b.stall_i = 0;
    drv(7'h52, 3'b010, 4, 9, 0, 32'h100, 0, 4, 32'h200);
    chk(0, S_STALLF, 0, "lw_nostall");
    chk(1, S_VALID, 1, "lw_valid");
    chk(1, S_CTRL, 32'h52, "lw_ctrl");
    chk(1, S_RT, 9, "lw_rt");
    tick();
    drv(7'h60, 3'b010, 9, 3, 11, 32'h11, 32'h22, 0, 32'h204);
    chk(0, S_STALLF, 1, "lu_stall_f");
    chk(0, S_STALLD, 1, "lu_stall_d");
    chk(1, S_VALID, 0, "lu_bub_valid");
    chk(1, S_CTRL, 0, "lu_bub_ctrl");
    chk(1, S_ALUC, 0, "lu_bub_aluc");
    chk(1, S_RS, 0, "lu_bub_rs");
    chk(1, S_SRCA, 0, "lu_bub_srca");
    chk(1, S_CNT, 1, "lu_cnt");
    tick();
    chk(0, S_STALLF, 0, "lu_release");
    chk(1, S_VALID, 1, "lu_load_valid");
    chk(1, S_CTRL, 32'h60, "lu_load_ctrl");
    chk(1, S_RS, 9, "lu_load_rs");
    chk(1, S_RD, 11, "lu_load_rd");
    chk(1, S_SRCA, 32'h11, "lu_load_srca");
    chk(1, S_CNT, 1, "lu_load_cnt");
    tick();
    drv(7'h52, 3'b010, 0, 0, 0, 32'h1, 0, 0, 32'h208);
    chk(0, S_STALLF, 0, "lw0_nostall");
    chk(1, S_VALID, 1, "lw0_valid");
    chk(1, S_RT, 0, "lw0_rt");
    tick();
    drv(7'h60, 3'b010, 0, 0, 12, 32'h33, 0, 0, 32'h20c);
    chk(0, S_STALLF, 0, "r0_nostall_f");
    chk(0, S_STALLD, 0, "r0_nostall_d");
    chk(1, S_VALID, 1, "r0_valid");
    chk(1, S_RD, 12, "r0_rd");
    chk(1, S_CNT, 1, "r0_cnt");
    tick();
    b.stall_i = 1;
    b.flush_i = 1;
    drv(7'h7f, 3'h7, 1, 2, 3, 32'hdead, 32'hbeef, 1, 2);
    for (int i = 0; i < 3; i++) begin
      chk(0, S_STALLF, 1, "hold_stall_f");
      chk(1, S_VALID, 1, "hold_valid");
      chk(1, S_CTRL, 32'h60, "hold_ctrl");
      chk(1, S_ALUC, 2, "hold_aluc");
      chk(1, S_RD, 12, "hold_rd");
      chk(1, S_SRCA, 32'h33, "hold_srca");
      tick();
    end
    b.stall_i = 0;
    chk(0, S_STALLF, 0, "flush_nostall");
    chk(1, S_VALID, 0, "flush_valid");
    chk(1, S_CTRL, 0, "flush_ctrl");
    chk(1, S_ALUC, 0, "flush_aluc");
    chk(1, S_RD, 0, "flush_rd");
    chk(1, S_SRCA, 0, "flush_srca");
    chk(1, S_CNT, 1, "flush_cnt");
    tick();
    chk(1, S_VALID, 0, "flush2_valid");
    chk(1, S_SRCA, 0, "flush2_srca");
    tick();
    rst = 1;
    b.flush_i = 0;
    chk(1, S_CNT, 0, "rst2_cnt");
    chk(1, S_VALID, 0, "rst2_valid");
    tick();
    rst = 0;
    drv(7'h52, 3'b010, 9, 9, 0, 32'h40, 0, 8, 32'h300);
    for (int i = 0; i < 5; i++) begin
      chk(0, S_STALLF, 0, "sat_load_nostall");
      chk(1, S_VALID, 1, "sat_load_valid");
      tick();
      if (i == 0) begin
        b.stall_i = 1;
        chk(0, S_STALLF, 1, "stallhaz_stall_f");
        chk(1, S_VALID, 1, "stallhaz_valid");
        chk(1, S_CTRL, 32'h52, "stallhaz_ctrl");
        chk(1, S_CNT, 0, "stallhaz_cnt");
        tick();
        b.stall_i = 0;
      end
      chk(0, S_STALLF, 1, "sat_stall_f");
      chk(0, S_STALLD, 1, "sat_stall_d");
      chk(1, S_VALID, 0, "sat_bub_valid");
      chk(1, S_CTRL, 0, "sat_bub_ctrl");
      chk(1, S_CNT, (i < 2) ? i + 1 : 3, "sat_cnt");
      tick();
    end
    for (int t = 0; t < 4 && q.size() > 0; t++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
